// File: rtl/spi_servo_pkg.sv
// Shared constants, FSM state type and address check for the SPI servo command receiver.
package spi_servo_pkg;

  localparam int unsigned FRAME_BITS     = 16;
  localparam int unsigned BYTE_BITS      = 8;
  localparam logic [7:0]  STATUS_BYTE    = 8'hA5;
  localparam int unsigned ADDR_VALID_MSB = 7;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DRAIN
  } state_e;

  function automatic logic addr_ok(input logic [7:0] addr, input int unsigned num_ch);
    return !addr[ADDR_VALID_MSB] && (32'(addr[6:0]) < num_ch);
  endfunction

endpackage

// File: rtl/spi_servo_cmd_sync_edge.sv
// Multi-stage synchroniser for one asynchronous input with registered rise/fall pulses.
module sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  always_comb begin
    level_o = sync_q[STAGES-1];
    rise_o  = sync_q[STAGES-1] & ~prev_q;
    fall_o  = ~sync_q[STAGES-1] & prev_q;
  end

endmodule

// File: rtl/spi_servo_cmd.sv
// SPI mode-0 slave decoding 2-byte (channel, position) frames into per-channel servo
// position registers, echoing status and the addressed channel's position on MISO.
module spi_servo_cmd
  import spi_servo_pkg::*;
#(
  parameter int unsigned NUM_CH      = 8,
  parameter logic [7:0]  DEFAULT_POS = 8'd128,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic                  sclk_i,
  input  logic                  cs_ni,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic [NUM_CH*8-1:0]   pos_o,
  output logic [NUM_CH-1:0]     update_o,
  output logic                  frame_err_o
);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i(clock_i), .rst_ni(reset_ni), .d_i(sclk_i),
    .level_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  // cs resets to "asserted" so a bus left low across reset never yields a fall;
  // a new frame is only accepted after cs has been seen high.
  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
    .clk_i(clock_i), .rst_ni(reset_ni), .d_i(cs_ni),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i(clock_i), .rst_ni(reset_ni), .d_i(mosi_i),
    .level_o(mosi_lvl), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [7:0]        rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        rd_q, rd_d;
  logic [7:0]        pos_q [NUM_CH];
  logic [7:0]        pos_d [NUM_CH];
  logic [NUM_CH-1:0] upd_q, upd_d;
  logic              err_q, err_d;

  logic [7:0] rx_shift;
  logic [7:0] rd_sel;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  if (cs_fall) state_d = ADDR;
        ADDR:  if (sclk_rise && cnt_q == 5'(BYTE_BITS - 1)) state_d = DATA;
        DATA:  if (sclk_rise && cnt_q == 5'(FRAME_BITS - 1)) state_d = DRAIN;
        DRAIN: state_d = DRAIN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rx_shift = {rx_q[6:0], mosi_lvl};
    rd_sel   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (addr_ok(rx_shift, NUM_CH) && rx_shift[6:0] == 7'(k)) rd_sel = pos_q[k];
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    rx_d   = rx_q;
    tx_d   = tx_q;
    addr_d = addr_q;
    rd_d   = rd_q;
    pos_d  = pos_q;
    upd_d  = '0;
    err_d  = 1'b0;
    if (cs_rise) begin
      if ((state_q == ADDR || state_q == DATA) && cnt_q != '0) err_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cs_fall) begin
            cnt_d = '0;
            rx_d  = '0;
            tx_d  = STATUS_BYTE;
          end
        end
        ADDR, DATA: begin
          if (sclk_rise) begin
            rx_d  = rx_shift;
            cnt_d = cnt_q + 5'd1;
            if (state_q == ADDR && cnt_q == 5'(BYTE_BITS - 1)) begin
              addr_d = rx_shift;
              rd_d   = rd_sel;
            end
            if (state_q == DATA && cnt_q == 5'(FRAME_BITS - 1)) begin
              if (addr_ok(addr_q, NUM_CH)) begin
                for (int unsigned k = 0; k < NUM_CH; k++) begin
                  if (addr_q[6:0] == 7'(k)) begin
                    pos_d[k] = rx_shift;
                    upd_d[k] = 1'b1;
                  end
                end
              end else begin
                err_d = 1'b1;
              end
            end
          end else if (sclk_fall) begin
            // The fall after the 8th rise presents the echo byte's MSB instead of shifting.
            if (cnt_q == 5'(BYTE_BITS)) tx_d = rd_q;
            else                        tx_d = {tx_q[6:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q  <= '0;
      rx_q   <= '0;
      tx_q   <= '0;
      addr_q <= '0;
      rd_q   <= '0;
      upd_q  <= '0;
      err_q  <= 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) pos_q[k] <= DEFAULT_POS;
    end else begin
      cnt_q  <= cnt_d;
      rx_q   <= rx_d;
      tx_q   <= tx_d;
      addr_q <= addr_d;
      rd_q   <= rd_d;
      upd_q  <= upd_d;
      err_q  <= err_d;
      pos_q  <= pos_d;
    end
  end

  always_comb begin
    miso_o = 1'b0;
    if ((state_q == ADDR || state_q == DATA) && !cs_lvl) miso_o = tx_q[7];
  end

  always_comb begin
    pos_o = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) pos_o[8*k +: 8] = pos_q[k];
    update_o    = upd_q;
    frame_err_o = err_q;
  end

endmodule
